cpu: RTL and testbench

CPU -- requirements
Module: cpu

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/cpu_if.sv | 29 ++
 rtl/cpu_regfile.sv | 32 +++
 rtl/cpu.sv | 173 +++++++++++++++++
 tb/tb_cpu.sv | 125 ++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants and types for the single-cycle RV32I subset
//               core: opcodes, funct3/funct7 codes and the ALU operation enum.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   // Major opcodes
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   // funct3 / funct7 codes
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [6:0] F7_BASE = 7'b0000000;

   localparam logic [31:0] C_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_AND = 2'd1,
      ALU_OR  = 2'd2
   } alu_op_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_if
// Description : Register-file access bundle: two combinational read ports and
//               one write port.
//   master : drives read addresses and the write port, receives read data
//   slave  : receives addresses/write port, returns read data
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_if;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        we;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;

   modport master (
      output rs1_addr, rs2_addr, we, rd_addr, rd_data,
      input  rs1_data, rs2_data
   );

   modport slave (
      input  rs1_addr, rs2_addr, we, rd_addr, rd_data,
      output rs1_data, rs2_data
   );
endinterface : cpu_if
`default_nettype wire

// File: rtl/cpu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile
// Description : 32 x 32-bit register file, combinational reads, one
//               synchronous write port. x0 reads as zero, writes to it are
//               dropped.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears all registers
//   bus   : cpu_if.slave register access bundle
// Revision    : 1.0 - initial release
// ============================================================================
module regfile (
   input  wire logic clk,
   input  wire logic rst_n,
   cpu_if.slave      bus
);

   logic [31:0] registers [0:31];

   assign bus.rs1_data = (bus.rs1_addr == 5'd0) ? 32'd0 : registers[bus.rs1_addr];
   assign bus.rs2_data = (bus.rs2_addr == 5'd0) ? 32'd0 : registers[bus.rs2_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) registers[i] <= 32'd0;
      end else if (bus.we && (bus.rd_addr != 5'd0)) begin
         registers[bus.rd_addr] <= bus.rd_data;
      end
   end

endmodule : regfile
`default_nettype wire

// File: rtl/cpu.sv
`default_nettype none
// ============================================================================
// Module      : cpu
// Description : Single-cycle RV32I subset core (lw, sw, add, and, or, addi,
//               beq, jal) with built-in program ROM and data RAM. Unknown
//               encodings retire as NOP.
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset (pc, run flag, registers)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu
   import cpu_pkg::*;
#(
   parameter int IMEM_WORDS = 64,
   parameter int DMEM_WORDS = 64
) (
   input wire logic clk,
   input wire logic rst_n
);

   localparam int C_IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
   localparam int C_DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

   logic [31:0] pc;
   logic        r_run;

   cpu_if rf_bus ();
   regfile regfile_u (.clk(clk), .rst_n(rst_n), .bus(rf_bus.slave));

   // ---------------- instruction ROM ----------------
   function automatic logic [31:0] imem_word(input logic [C_IAW-1:0] idx);
      case (32'(idx))
         32'd0:   return 32'h00C0_2903; // lw  x18,12(x0)
         32'd1:   return 32'h0120_2823; // sw  x18,16(x0)
         32'd2:   return 32'h0140_2883; // lw  x17,20(x0)
         32'd3:   return 32'h0119_09B3; // add x19,x18,x17
         32'd4:   return 32'h0139_7AB3; // and x21,x18,x19
         32'd5:   return 32'h0180_2283; // lw  x5,24(x0)
         32'd6:   return 32'h01C0_2303; // lw  x6,28(x0)
         32'd7:   return 32'h0062_E3B3; // or  x7,x5,x6
         32'd9:   return 32'h0073_0663; // beq x6,x7,12
         32'd10:  return 32'h0080_2B03; // lw  x22,8(x0)
         32'd11:  return 32'h0169_0863; // beq x18,x22,16
         32'd14:  return 32'h0000_0663; // beq x0,x0,12
         32'd15:  return 32'h0000_2B03; // lw  x22,0(x0)
         32'd16:  return 32'hFF6B_0CE3; // beq x22,x22,-8
         32'd18:  return 32'h00C0_00EF; // jal x1,12
         32'd20:  return 32'h00C0_00EF; // jal x1,12
         32'd21:  return 32'hFFDF_F0EF; // jal x1,-4
         32'd23:  return 32'h00C0_2383; // lw  x7,12(x0)
         default: return C_NOP;
      endcase
   endfunction

   logic [C_IAW-1:0] w_iidx;
   logic [31:0]      w_instr;
   assign w_iidx  = C_IAW'(32'(pc[31:2]) % 32'(IMEM_WORDS));
   assign w_instr = imem_word(w_iidx);

   // ---------------- decode / immediates ----------------
   logic [6:0]  w_opcode, w_f7;
   logic [2:0]  w_f3;
   logic [4:0]  w_rd;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;

   assign w_opcode = w_instr[6:0];
   assign w_rd     = w_instr[11:7];
   assign w_f3     = w_instr[14:12];
   assign w_f7     = w_instr[31:25];
   assign w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
   assign w_imm_s  = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
   assign w_imm_b  = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                      w_instr[30:25], w_instr[11:8], 1'b0};
   assign w_imm_j  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                      w_instr[20], w_instr[30:21], 1'b0};

   assign rf_bus.rs1_addr = w_instr[19:15];
   assign rf_bus.rs2_addr = w_instr[24:20];

   // ---------------- control, ALU, next pc ----------------
   alu_op_e     w_alu_op;
   logic [31:0] w_alu_b, w_alu_res, w_wb_data, w_next_pc, w_pc_plus4;
   logic [31:0] w_dmem_rdata;
   logic        w_rf_we, w_mem_we;
   logic [C_DAW-1:0] w_didx;

   assign w_pc_plus4 = pc + 32'd4;

   always_comb begin
      w_alu_op  = ALU_ADD;
      w_alu_b   = rf_bus.rs2_data;
      w_rf_we   = 1'b0;
      w_mem_we  = 1'b0;
      w_next_pc = w_pc_plus4;
      case (w_opcode)
         OPC_LOAD: if (w_f3 == F3_WORD) begin
            w_alu_b = w_imm_i;
            w_rf_we = 1'b1;
         end
         OPC_STORE: if (w_f3 == F3_WORD) begin
            w_alu_b  = w_imm_s;
            w_mem_we = 1'b1;
         end
         OPC_OP: if (w_f7 == F7_BASE) begin
            case (w_f3)
               F3_ADD: begin w_alu_op = ALU_ADD; w_rf_we = 1'b1; end
               F3_AND: begin w_alu_op = ALU_AND; w_rf_we = 1'b1; end
               F3_OR:  begin w_alu_op = ALU_OR;  w_rf_we = 1'b1; end
               default: ;
            endcase
         end
         OPC_OP_IMM: if (w_f3 == F3_ADD) begin
            w_alu_b = w_imm_i;
            w_rf_we = 1'b1;
         end
         OPC_BRANCH: if (w_f3 == F3_BEQ) begin
            if (rf_bus.rs1_data == rf_bus.rs2_data) w_next_pc = pc + w_imm_b;
         end
         OPC_JAL: begin
            w_rf_we   = 1'b1;
            w_next_pc = pc + w_imm_j;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (w_alu_op)
         ALU_AND: w_alu_res = rf_bus.rs1_data & w_alu_b;
         ALU_OR:  w_alu_res = rf_bus.rs1_data | w_alu_b;
         default: w_alu_res = rf_bus.rs1_data + w_alu_b;
      endcase
   end

   assign w_didx    = C_DAW'(32'(w_alu_res[31:2]) % 32'(DMEM_WORDS));
   assign w_wb_data = (w_opcode == OPC_LOAD) ? w_dmem_rdata :
                      (w_opcode == OPC_JAL)  ? w_pc_plus4   : w_alu_res;

   // r_run gates all writes, so the start-up edge and any edge during reset
   // leave registers and memory untouched.
   assign rf_bus.we      = r_run & w_rf_we;
   assign rf_bus.rd_addr = w_rd;
   assign rf_bus.rd_data = w_wb_data;

   // ---------------- data memory (not affected by reset) ----------------
   if (1) begin : dmemory
      logic [31:0] mem [0:DMEM_WORDS-1] = '{
         0: 32'hAEAE_AEAE, 2: 32'hABCD_EF11, 3: 32'hABCD_EF11,
         4: 32'hF2F2_F2F2, 5: 32'h1234_5678, 6: 32'h125F_552D,
         7: 32'h7F4F_D46A, default: 32'h0
      };

      assign w_dmem_rdata = mem[w_didx];

      always_ff @(posedge clk) begin
         if (r_run && w_mem_we) mem[w_didx] <= rf_bus.rs2_data;
      end
   end

   // ---------------- pc / run flag ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc    <= 32'd0;
         r_run <= 1'b0;
      end else if (!r_run) begin
         r_run <= 1'b1;
      end else begin
         pc <= w_next_pc;
      end
   end

endmodule : cpu
`default_nettype wire

// File: tb/tb_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu
// Description : Directed self-checking bench for cpu: walks the built-in
//               program edge by edge, then applies a mid-program reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   cpu #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (.clk(clk), .rst_n(rst_n));

   // Monitor copy of the internal register-file write port
   cpu_if u_mon ();
   assign u_mon.we       = dut.rf_bus.we;
   assign u_mon.rd_addr  = dut.rf_bus.rd_addr;
   assign u_mon.rd_data  = dut.rf_bus.rd_data;
   assign u_mon.rs1_addr = dut.rf_bus.rs1_addr;
   assign u_mon.rs2_addr = dut.rf_bus.rs2_addr;
   assign u_mon.rs1_data = dut.rf_bus.rs1_data;
   assign u_mon.rs2_data = dut.rf_bus.rs2_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] nonzero_regs();
      logic [31:0] n = 32'd0;
      for (int i = 0; i < 32; i++)
         if (dut.regfile_u.registers[i] !== 32'd0) n++;
      return n;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      #12;
      check("reset_pc",  dut.pc, 32'h0);
      check("reset_regs", nonzero_regs(), 32'd0);
      rst_n = 1'b1;

      tick(); // edge 1: start-up only
      check("e1_pc",  dut.pc, 32'h0);
      check("e1_x18", dut.regfile_u.registers[18], 32'h0);
      tick(); // edge 2
      check("e2_x18",  dut.regfile_u.registers[18], 32'hABCDEF11);
      check("e2_mem4", dut.dmemory.mem[4], 32'hF2F2F2F2);
      check("e2_pc",   dut.pc, 32'h4);
      tick(); // edge 3
      check("e3_mem4", dut.dmemory.mem[4], 32'hABCDEF11);
      tick(); check("e4_x17", dut.regfile_u.registers[17], 32'h12345678);
      tick(); check("e5_x19", dut.regfile_u.registers[19], 32'hBE024589);
      tick(); check("e6_x21", dut.regfile_u.registers[21], 32'hAA004501);
      tick(); check("e7_x5",  dut.regfile_u.registers[5],  32'h125F552D);
      tick(); check("e8_x6",  dut.regfile_u.registers[6],  32'h7F4FD46A);
      tick(); check("e9_x7",  dut.regfile_u.registers[7],  32'h7F5FD56F);
      tick(); check("e10_pc", dut.pc, 32'h24);
      tick(); check("e11_pc", dut.pc, 32'h28);
      tick(); check("e12_x22", dut.regfile_u.registers[22], 32'hABCDEF11);
      tick(); check("e13_pc", dut.pc, 32'h3C);
      tick(); check("e14_x22", dut.regfile_u.registers[22], 32'hAEAEAEAE);
      tick(); check("e15_pc", dut.pc, 32'h38);
      tick(); check("e16_pc", dut.pc, 32'h44);
      tick(); check("e17_pc", dut.pc, 32'h48);
      tick();
      check("e18_pc", dut.pc, 32'h54);
      check("e18_x1", dut.regfile_u.registers[1], 32'h4C);
      tick();
      check("e19_pc", dut.pc, 32'h50);
      check("e19_x1", dut.regfile_u.registers[1], 32'h58);
      tick();
      check("e20_pc", dut.pc, 32'h5C);
      check("e20_x1", dut.regfile_u.registers[1], 32'h54);
      check("e21_pend_we",   {31'd0, u_mon.we}, 32'd1);
      check("e21_pend_rd",   {27'd0, u_mon.rd_addr}, 32'd7);
      check("e21_pend_data", u_mon.rd_data, 32'hABCDEF11);
      tick();
      check("e21_x7", dut.regfile_u.registers[7], 32'hABCDEF11);
      check("e21_pc", dut.pc, 32'h60);
      check("x0_zero", dut.regfile_u.registers[0], 32'h0);

      // Mid-program reset, asserted between edges
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_reset_pc",   dut.pc, 32'h0);
      check("mid_reset_regs", nonzero_regs(), 32'd0);
      check("mid_reset_mem4", dut.dmemory.mem[4], 32'hABCDEF11);
      tick(); // edge while held in reset
      check("hold_pc", dut.pc, 32'h0);
      #2;
      rst_n = 1'b1;
      tick();
      check("rst_e1_pc",  dut.pc, 32'h0);
      check("rst_e1_x18", dut.regfile_u.registers[18], 32'h0);
      tick();
      check("rst_e2_pc",  dut.pc, 32'h4);
      check("rst_e2_x18", dut.regfile_u.registers[18], 32'hABCDEF11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_cpu
`default_nettype wire
